bus_decode_mux: RTL and testbench
=================================

BUS_DECODE_MUX -- requirements
Module: bus_decode_mux

Interface
REQ-001 NumSlaves, default 4, number of decoded slave windows (1..16).
REQ-002 address_width, default 32, CPU address width.
REQ-003 data_width, default 32, read-data width.
REQ-004 BaseAddrs, default {0x0000,0x1000,0x2000,0x3000}, packed NumSlaves*address_width inclusive window starts; slot i = slave i.
REQ-005 EndAddrs, default {0x0FFF,0x1FFF,0x2FFF,0x3FFF}, packed inclusive window ends.
REQ-006 WaitStates, default {0,1,3,0}, packed NumSlaves*2 bits, per-slave extra read/write wait cycles (0..3).
REQ-007 DefaultData, default 32'hDEADBEEF, data returned on unmapped access.
REQ-008 clk_i  in  1  sole clock; all logic rising-edge.
REQ-009 reset_i  in  1  synchronous, active-high reset.
REQ-010 address_i  in  address_width  CPU address, sampled when request accepted.
REQ-011 req_i  in  1  CPU access strobe (read or write), one cycle per access.
REQ-012 we_i  in  1  1 = write, 0 = read; sampled with req_i.
REQ-013 slave_data_i  in  NumSlaves*data_width  slave read data; slot i = slave i.
REQ-014 data_o  out  data_width  read data to CPU, valid only while ready_o = 1.
REQ-015 ready_o  out  1  one-cycle pulse: access complete.
REQ-016 sel_o  out  NumSlaves  one-hot select of active slave.
REQ-017 err_o  out  1  one-cycle pulse on unmapped access.
REQ-018 err_count_o  out  16  saturating unmapped-access count.
REQ-019 err_addr_o  out  address_width  address of most recent unmapped access.

Function
REQ-020 Decode: slave i hits when BaseAddrs[i] <= address <= EndAddrs[i]; on overlap lowest index wins; no hit = unmapped.
REQ-021 FSM states IDLE, WAIT, RESP; accept = req_i high in IDLE or RESP.
REQ-022 On accept at cycle N: latch slave index, we_i, address; load wait counter with WaitStates[idx] (0 if unmapped).
REQ-023 Counter 0 -> RESP at N+1; counter W>0 -> WAIT, decrement each cycle, enter RESP at N+1+W.
REQ-024 In RESP, ready_o = 1 for exactly one cycle; data_o = slave_data_i[latched idx] combinationally for reads, DefaultData for unmapped reads, 0 for writes.
REQ-025 data_o = 0 whenever ready_o = 0.
REQ-026 sel_o = one-hot of latched idx throughout WAIT and RESP for mapped accesses; 0 in IDLE and for unmapped accesses.
REQ-027 req_i in RESP is accepted (back-to-back); zero-wait slaves sustain one access per cycle.
REQ-028 req_i in WAIT is ignored; no queuing, no ready_o generated for it.
REQ-029 RESP without req_i -> IDLE.
REQ-030 Unmapped access: ready_o and err_o both pulse at N+1; err_addr_o updated at N+1; err_count_o increments at N+1, saturating at 0xFFFF.
REQ-031 Write accesses follow identical timing and error rules as reads.

Reset
REQ-032 reset_i high at any clock edge: state IDLE, wait counter 0, ready_o/err_o/sel_o/data_o 0, err_count_o 0, err_addr_o 0.
REQ-033 Reset during WAIT or RESP aborts the access; no ready_o issued for it after reset release.
REQ-034 req_i in the cycle reset_i is high is ignored; first acceptable request is the cycle after release.

Verification (default parameters)
REQ-035 Read 0x0010 (slave 0, W=0), slave0 data 0x11111111 at N -> ready_o=1, data_o=0x11111111, sel_o=0001 at N+1.
REQ-036 Read 0x2004 (slave 2, W=3) at N, req_i pulsed again at N+2 -> sel_o=0100 N+1..N+4, single ready_o at N+4, second req ignored.
REQ-037 Back-to-back reads 0x0000, 0x3000, 0x0004 at N..N+2 -> ready_o high N+1..N+3 with slave 0, 3, 0 data respectively.
REQ-038 Read 0x8000 -> ready_o=1, err_o=1, data_o=0xDEADBEEF, sel_o=0, err_addr_o=0x8000, err_count_o=1 at N+1; 70000 unmapped accesses -> err_count_o=0xFFFF.
REQ-039 Read 0x1000 (W=1) at N, reset_i high at N+1 -> no ready_o at N+2 or later, all outputs 0, err_count_o=0.
REQ-040 Write 0x3008, we_i=1 -> ready_o=1, data_o=0, sel_o=1000 at N+1, err_o=0.

Source files
------------

// File: rtl/bus_decode_mux.sv
// bus_decode_mux: decodes a CPU address into one of NumSlaves inclusive
// address windows, inserts the per-slave wait states and returns the read
// data of the selected slave. Unmapped accesses complete with DefaultData and
// an error pulse, and are tallied in a saturating counter alongside the most
// recent offending address.
//
// Handshake: an access is a single-cycle req_i strobe. It is accepted only in
// IDLE or RESP. A strobe seen in WAIT is dropped: it is not queued and gets no
// response. Each accepted access gets exactly one ready_o pulse, W+1 cycles
// after acceptance, where W is the wait count of the decoded slave (0 for
// unmapped). data_o is meaningful only while ready_o is high and reads as zero
// otherwise. A reset aborts any access in flight, and that access never
// receives a ready_o.
module bus_decode_mux #(
  parameter int NumSlaves = 4,
  parameter int address_width = 32,
  parameter int data_width = 32,
  parameter logic [NumSlaves*address_width-1:0] BaseAddrs =
    {32'h0000_3000, 32'h0000_2000, 32'h0000_1000, 32'h0000_0000},
  parameter logic [NumSlaves*address_width-1:0] EndAddrs =
    {32'h0000_3FFF, 32'h0000_2FFF, 32'h0000_1FFF, 32'h0000_0FFF},
  parameter logic [NumSlaves*2-1:0] WaitStates = {2'd0, 2'd3, 2'd1, 2'd0},
  parameter logic [data_width-1:0] DefaultData = 32'hDEAD_BEEF
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [address_width-1:0]        address_i,
  input  logic                            req_i,
  input  logic                            we_i,
  input  logic [NumSlaves*data_width-1:0] slave_data_i,
  output logic [data_width-1:0]           data_o,
  output logic                            ready_o,
  output logic [NumSlaves-1:0]            sel_o,
  output logic                            err_o,
  output logic [15:0]                     err_count_o,
  output logic [address_width-1:0]        err_addr_o,
  output logic [1:0]                      state_o
);

  localparam int IdxW = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q;
  logic              hit_q;
  logic              we_q;
  logic [15:0]       err_count_q;
  logic [address_width-1:0] err_addr_q;

  logic              dec_hit;
  logic [IdxW-1:0]   dec_idx;
  logic [1:0]        dec_wait;
  logic              accept;
  logic [data_width-1:0] rd_data;

  // Address decode: walk from the highest slot down so the lowest matching
  // index is the one left standing when windows overlap.
  always_comb begin
    dec_hit  = 1'b0;
    dec_idx  = '0;
    dec_wait = 2'd0;
    for (int i = NumSlaves - 1; i >= 0; i--) begin
      if (!(address_i < BaseAddrs[i*address_width +: address_width]) &&
          !(address_i > EndAddrs[i*address_width +: address_width])) begin
        dec_hit  = 1'b1;
        dec_idx  = IdxW'(i);
        dec_wait = WaitStates[i*2 +: 2];
      end
    end
  end

  // New access may be taken when idle or while finishing the previous one.
  assign accept = req_i && ((state_q == S_IDLE) || (state_q == S_RESP));

  // Next-state and wait-counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (req_i) begin
          cnt_d   = dec_wait;
          state_d = (dec_wait == 2'd0) ? S_RESP : S_WAIT;
        end else begin
          cnt_d   = 2'd0;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        // Counter holds the remaining wait cycles including this one.
        if (cnt_q <= 2'd1) begin
          cnt_d   = 2'd0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: begin
        cnt_d   = 2'd0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register and wait counter.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the decoded access attributes when an access is accepted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      idx_q <= '0;
      hit_q <= 1'b0;
      we_q  <= 1'b0;
    end else if (accept) begin
      idx_q <= dec_idx;
      hit_q <= dec_hit;
      we_q  <= we_i;
    end
  end

  // Unmapped-access bookkeeping: saturating count and last offending address.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_count_q <= 16'd0;
      err_addr_q  <= '0;
    end else if (accept && !dec_hit) begin
      err_addr_q <= address_i;
      if (err_count_q != 16'hFFFF) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  // Read-data mux over the latched slave index.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      if (idx_q == IdxW'(i)) begin
        rd_data = slave_data_i[i*data_width +: data_width];
      end
    end
  end

  // Response outputs: select is held through WAIT and RESP, data only in RESP.
  always_comb begin
    ready_o = (state_q == S_RESP);
    err_o   = ready_o && !hit_q;
    sel_o   = '0;
    for (int i = 0; i < NumSlaves; i++) begin
      sel_o[i] = (state_q != S_IDLE) && hit_q && (idx_q == IdxW'(i));
    end
    data_o = '0;
    if (ready_o && !we_q) begin
      data_o = hit_q ? rd_data : DefaultData;
    end
  end

  assign err_count_o = err_count_q;
  assign err_addr_o  = err_addr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_bus_decode_mux.sv
// Directed and randomised checks of bus_decode_mux with default parameters.
module tb_bus_decode_mux;

  localparam int W = 37;  // {err, sel[3:0], data[31:0]}

  logic         clk = 1'b0;
  logic         reset_i;
  logic [31:0]  address_i;
  logic         req_i;
  logic         we_i;
  logic [127:0] slave_data_i;
  logic [31:0]  data_o;
  logic         ready_o;
  logic [3:0]   sel_o;
  logic         err_o;
  logic [15:0]  err_count_o;
  logic [31:0]  err_addr_o;
  logic [1:0]   state_o;

  logic [31:0]  sd [4];
  logic [W-1:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  int           exp_errs = 0;
  logic [31:0]  last_err_addr = 32'h0;

  assign slave_data_i = {sd[3], sd[2], sd[1], sd[0]};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  bus_decode_mux dut (
    .clk_i(clk), .reset_i(reset_i), .address_i(address_i), .req_i(req_i),
    .we_i(we_i), .slave_data_i(slave_data_i), .data_o(data_o),
    .ready_o(ready_o), .sel_o(sel_o), .err_o(err_o),
    .err_count_o(err_count_o), .err_addr_o(err_addr_o), .state_o(state_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference decode: windows of 4 KiB at 0x0000..0x3FFF, everything else unmapped.
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic w);
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
    if (a <= 32'h3FFF) begin
      s = 4'b0001 << a[13:12];
      e = 1'b0;
      d = w ? 32'h0 : sd[a[13:12]];
    end else begin
      s = 4'b0000;
      e = 1'b1;
      d = w ? 32'h0 : 32'hDEAD_BEEF;
    end
    return {e, s, d};
  endfunction

  function automatic int model_wait(input logic [31:0] a);
    if (a > 32'h3FFF) return 0;
    case (a[13:12])
      2'd1: return 1;
      2'd2: return 3;
      default: return 0;
    endcase
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic w);
    address_i = a;
    we_i      = w;
    req_i     = 1'b1;
    exp_q.push_back(model(a, w));
    if (a > 32'h3FFF) begin
      exp_errs++;
      last_err_addr = a;
    end
  endtask

  // scoreboard: every ready pulse must match the oldest outstanding access
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (ready_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 64'(ready_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("response", 64'({err_o, sel_o, data_o}), 64'(e));
      end
    end else begin
      check("idle_data", 64'(data_o), 64'd0);
      check("idle_err", 64'(err_o), 64'd0);
    end
  end

  initial begin
    int lat;
    logic [31:0] a;
    logic w;
    reset_i = 1'b1; req_i = 1'b0; we_i = 1'b0; address_i = 32'h0;
    sd[0] = 32'h1111_1111; sd[1] = 32'h2222_2222;
    sd[2] = 32'h3333_3333; sd[3] = 32'h4444_4444;
    tick(); tick();
    check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_sel", 64'(sel_o), 64'd0);
    check("rst_data", 64'(data_o), 64'd0);
    check("rst_cnt", 64'(err_count_o), 64'd0);
    check("rst_addr", 64'(err_addr_o), 64'd0);
    check("rst_state", 64'(state_o), 64'd0);

    // request during the last reset cycle must be ignored
    address_i = 32'h8000; req_i = 1'b1;
    tick();
    reset_i = 1'b0; req_i = 1'b0;
    check("rst_req_ready", 64'(ready_o), 64'd0);
    tick();
    check("rst_req_ready2", 64'(ready_o), 64'd0);
    check("rst_req_cnt", 64'(err_count_o), 64'd0);

    // single zero-wait read of slave 0
    issue(32'h0010, 1'b0);
    tick(); req_i = 1'b0;
    check("r0_ready", 64'(ready_o), 64'd1);
    check("r0_data", 64'(data_o), 64'h1111_1111);
    check("r0_sel", 64'(sel_o), 64'b0001);
    tick();
    check("r0_idle", 64'(ready_o), 64'd0);

    // three-wait read of slave 2 with a dropped strobe during WAIT
    issue(32'h2004, 1'b0);
    tick(); req_i = 1'b0;
    check("w3_sel1", 64'(sel_o), 64'b0100);
    check("w3_rdy1", 64'(ready_o), 64'd0);
    tick();
    check("w3_sel2", 64'(sel_o), 64'b0100);
    address_i = 32'h0000; req_i = 1'b1;  // no push: must be dropped
    tick(); req_i = 1'b0;
    check("w3_sel3", 64'(sel_o), 64'b0100);
    check("w3_rdy3", 64'(ready_o), 64'd0);
    tick();
    check("w3_rdy4", 64'(ready_o), 64'd1);
    check("w3_data4", 64'(data_o), 64'h3333_3333);
    check("w3_sel4", 64'(sel_o), 64'b0100);
    tick();
    check("w3_rdy5", 64'(ready_o), 64'd0);
    check("w3_sel5", 64'(sel_o), 64'd0);

    // back-to-back zero-wait reads with fresh slave data
    for (int i = 0; i < 4; i++) sd[i] = $urandom;
    issue(32'h0000, 1'b0);
    tick();
    check("b2b_rdy1", 64'(ready_o), 64'd1);
    issue(32'h3000, 1'b0);
    tick();
    check("b2b_rdy2", 64'(ready_o), 64'd1);
    check("b2b_data2", 64'(data_o), 64'(sd[3]));
    issue(32'h0004, 1'b0);
    tick(); req_i = 1'b0;
    check("b2b_rdy3", 64'(ready_o), 64'd1);
    check("b2b_data3", 64'(data_o), 64'(sd[0]));
    tick();
    check("b2b_idle", 64'(ready_o), 64'd0);

    // unmapped read
    issue(32'h8000, 1'b0);
    tick(); req_i = 1'b0;
    check("um_err", 64'(err_o), 64'd1);
    check("um_data", 64'(data_o), 64'hDEAD_BEEF);
    check("um_sel", 64'(sel_o), 64'd0);
    check("um_addr", 64'(err_addr_o), 64'h8000);
    check("um_cnt", 64'(err_count_o), 64'd1);
    tick();

    // write to slave 3, then unmapped write
    issue(32'h3008, 1'b1);
    tick(); req_i = 1'b0;
    check("wr_ready", 64'(ready_o), 64'd1);
    check("wr_data", 64'(data_o), 64'd0);
    check("wr_sel", 64'(sel_o), 64'b1000);
    check("wr_err", 64'(err_o), 64'd0);
    issue(32'h4000, 1'b1);
    tick(); req_i = 1'b0;
    check("uw_err", 64'(err_o), 64'd1);
    check("uw_data", 64'(data_o), 64'd0);
    check("uw_cnt", 64'(err_count_o), 64'(exp_errs));
    tick();

    // window edges and random accesses with latency check
    for (int k = 0; k < 24; k++) begin
      case (k)
        0: a = 32'h0FFF;
        1: a = 32'h1000;
        2: a = 32'h1FFF;
        3: a = 32'h2000;
        4: a = 32'h3FFF;
        5: a = 32'h4000;
        default: a = $urandom_range(0, 32'h4FFF);
      endcase
      w = 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) sd[i] = $urandom;
      issue(a, w);
      tick(); req_i = 1'b0;
      lat = 1;
      while (!ready_o && lat < 8) begin
        tick();
        lat++;
      end
      check("rand_latency", 64'(lat), 64'(model_wait(a) + 1));
      check("rand_errcnt", 64'(err_count_o), 64'(exp_errs));
      tick();
    end

    // saturation: stream of unmapped accesses
    for (int k = 0; k < 70000; k++) begin
      issue($urandom_range(32'h4000, 32'hFFFF_FFFF), 1'($urandom_range(0, 1)));
      tick();
    end
    req_i = 1'b0;
    tick();
    check("sat_cnt", 64'(err_count_o), 64'hFFFF);
    check("sat_addr", 64'(err_addr_o), 64'(last_err_addr));

    // reset during WAIT aborts the access and clears the counters
    issue(32'h1000, 1'b0);
    tick(); req_i = 1'b0;
    check("ab_sel", 64'(sel_o), 64'b0010);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    exp_q.delete();
    exp_errs = 0;
    check("ab_ready", 64'(ready_o), 64'd0);
    check("ab_sel0", 64'(sel_o), 64'd0);
    check("ab_data", 64'(data_o), 64'd0);
    check("ab_cnt", 64'(err_count_o), 64'd0);
    check("ab_addr", 64'(err_addr_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("ab_noready", 64'(ready_o), 64'd0);
    end

    tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
